// File: rtl/imem_loader.sv
// imem_loader: turns a host byte stream (16-bit word count, then 4*N bytes)
// into 32-bit little-endian word writes on the instruction memory write port.
// Keeps the core held in reset until the whole program has landed in memory.
module imem_loader #(
    parameter int unsigned MEM_BYTES = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,          // active-low, asynchronous
    input  logic        start_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic        in_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        cpu_hold_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] words_loaded_o
);

    localparam logic [31:0] CAP_WORDS = 32'(MEM_BYTES / 4);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] n_q, n_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] wbuf_q, wbuf_d;        // lanes 0..2; lane 3 goes straight to mem_wdata

    logic        in_ready_q, in_ready_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] words_loaded_q, words_loaded_d;

    logic        accept;
    logic [15:0] n_new;

    assign accept = in_valid_i & in_ready_q;
    assign n_new  = {in_data_i, len_lo_q};

    // Next-state and datapath; output flags are derived from the state being entered
    // so every output is a flop that matches the state it reports.
    always_comb begin
        state_d        = state_q;
        len_lo_d       = len_lo_q;
        n_d            = n_q;
        word_idx_d     = word_idx_q;
        byte_idx_d     = byte_idx_q;
        wbuf_d         = wbuf_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        words_loaded_d = words_loaded_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d        = S_LEN0;
                    words_loaded_d = 16'd0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_lo_d = in_data_i;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    n_d = n_new;
                    if (n_new == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({16'd0, n_new} > CAP_WORDS) begin
                        state_d = S_ERR;
                    end else begin
                        state_d    = S_DATA;
                        word_idx_d = 16'd0;
                        byte_idx_d = 2'd0;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: wbuf_d[7:0]   = in_data_i;
                        2'd1: wbuf_d[15:8]  = in_data_i;
                        2'd2: wbuf_d[23:16] = in_data_i;
                        default: begin
                            // Last lane: the word is complete, latch the write beat.
                            state_d     = S_WRITE;
                            mem_addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                            mem_wdata_d = {in_data_i, wbuf_q};
                        end
                    endcase
                end
            end
            S_WRITE: begin
                word_idx_d     = word_idx_q + 16'd1;
                words_loaded_d = words_loaded_q + 16'd1;
                byte_idx_d     = 2'd0;
                if (word_idx_q + 16'd1 == n_q) state_d = S_DONE;
                else                           state_d = S_DATA;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
        mem_we_d   = (state_d == S_WRITE);
        cpu_hold_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
    end

    // State and output registers; reset discards any partially assembled word.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q        <= S_IDLE;
            len_lo_q       <= 8'd0;
            n_q            <= 16'd0;
            word_idx_q     <= 16'd0;
            byte_idx_q     <= 2'd0;
            wbuf_q         <= 24'd0;
            in_ready_q     <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 32'd0;
            mem_wdata_q    <= 32'd0;
            cpu_hold_q     <= 1'b1;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            words_loaded_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            len_lo_q       <= len_lo_d;
            n_q            <= n_d;
            word_idx_q     <= word_idx_d;
            byte_idx_q     <= byte_idx_d;
            wbuf_q         <= wbuf_d;
            in_ready_q     <= in_ready_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            cpu_hold_q     <= cpu_hold_d;
            done_q         <= done_d;
            err_q          <= err_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign in_ready_o     = in_ready_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign cpu_hold_o     = cpu_hold_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign words_loaded_o = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: cycle-exact vector table plus hand sequences for
// stream gaps, reset mid-word, start pulses mid-load and reload from DONE.
module tb_imem_loader;

    logic        clk, rst, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, cpu_hold, done, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [15:0] words_loaded;

    imem_loader #(.MEM_BYTES(4096), .BASE_ADDR(32'h0)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid),
        .in_data_i(in_data), .in_ready_o(in_ready), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .cpu_hold_o(cpu_hold),
        .done_o(done), .err_o(err), .words_loaded_o(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rdy, we;
        logic [31:0] addr, wdata;
        logic        hold, dn, er;
        logic [15:0] wl;
    } out_t;

    typedef struct {
        logic       s, v;
        logic [7:0] d;
        out_t       exp;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    vec_t tbl[$];
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    // Record every write beat seen on the memory port.
    always @(negedge clk) if (mem_we) begin wa.push_back(mem_addr); wd.push_back(mem_wdata); end

    function automatic out_t cur();
        return '{in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err, words_loaded};
    endfunction

    function automatic out_t mo(logic r, logic w, logic [31:0] a, logic [31:0] dd,
                                logic h, logic dn, logic e, logic [15:0] l);
        return '{r, w, a, dd, h, dn, e, l};
    endfunction

    function automatic void add(logic s, logic v, logic [7:0] d, out_t e);
        vec_t x;
        x.s = s; x.v = v; x.d = d; x.exp = e;
        tbl.push_back(x);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(string nm, out_t e);
        out_t a;
        a = cur();
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b wl=%0d expected rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b wl=%0d",
                     nm, a.rdy, a.we, a.addr, a.wdata, a.hold, a.dn, a.er, a.wl,
                     e.rdy, e.we, e.addr, e.wdata, e.hold, e.dn, e.er, e.wl);
        end
    endtask

    // Called at a negedge; presents b and returns at the negedge after it was accepted.
    task automatic send(logic [7:0] b, int gap);
        int g;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        g = 0;
        while (!in_ready && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) begin n_cmp++; n_err++; $display("FAIL send_timeout: byte %h never accepted", b); end
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(string nm);
        int g;
        g = 0;
        in_valid = 1'b0;
        while (!done && g < 20) begin @(negedge clk); g++; end
        chk(nm, {31'd0, done}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #12;
        chk_out("reset_state", mo(0, 0, 0, 0, 1, 0, 0, 0));

        // Test 1: two-word load, one bubble after the first write.
        add(1, 0, 8'h00, mo(1, 0, 0, 0, 1, 0, 0, 0));
        add(0, 1, 8'h02, mo(1, 0, 0, 0, 1, 0, 0, 0));
        add(0, 1, 8'h00, mo(1, 0, 0, 0, 1, 0, 0, 0));
        add(0, 1, 8'h00, mo(1, 0, 0, 0, 1, 0, 0, 0));
        add(0, 1, 8'h00, mo(1, 0, 0, 0, 1, 0, 0, 0));
        add(0, 1, 8'h01, mo(1, 0, 0, 0, 1, 0, 0, 0));
        add(0, 1, 8'h20, mo(0, 1, 0, 32'h2001_0000, 1, 0, 0, 0));
        add(0, 0, 8'h00, mo(1, 0, 0, 32'h2001_0000, 1, 0, 0, 1));
        add(0, 1, 8'h00, mo(1, 0, 0, 32'h2001_0000, 1, 0, 0, 1));
        add(0, 1, 8'h00, mo(1, 0, 0, 32'h2001_0000, 1, 0, 0, 1));
        add(0, 1, 8'h02, mo(1, 0, 0, 32'h2001_0000, 1, 0, 0, 1));
        add(0, 1, 8'h20, mo(0, 1, 4, 32'h2002_0000, 1, 0, 0, 1));
        add(0, 0, 8'h00, mo(0, 0, 4, 32'h2002_0000, 0, 1, 0, 2));
        // Test 2: empty program straight to DONE.
        add(1, 0, 8'h00, mo(1, 0, 4, 32'h2002_0000, 1, 0, 0, 0));
        add(0, 1, 8'h00, mo(1, 0, 4, 32'h2002_0000, 1, 0, 0, 0));
        add(0, 1, 8'h00, mo(0, 0, 4, 32'h2002_0000, 0, 1, 0, 0));
        // Test 3: N=1025 exceeds capacity; bytes ignored in ERR; restart clears err.
        add(1, 0, 8'h00, mo(1, 0, 4, 32'h2002_0000, 1, 0, 0, 0));
        add(0, 1, 8'h01, mo(1, 0, 4, 32'h2002_0000, 1, 0, 0, 0));
        add(0, 1, 8'h04, mo(0, 0, 4, 32'h2002_0000, 1, 0, 1, 0));
        add(0, 1, 8'h55, mo(0, 0, 4, 32'h2002_0000, 1, 0, 1, 0));
        add(1, 0, 8'h00, mo(1, 0, 4, 32'h2002_0000, 1, 0, 0, 0));
        add(0, 1, 8'h01, mo(1, 0, 4, 32'h2002_0000, 1, 0, 0, 0));
        add(0, 1, 8'h00, mo(1, 0, 4, 32'h2002_0000, 1, 0, 0, 0));
        add(0, 1, 8'h11, mo(1, 0, 4, 32'h2002_0000, 1, 0, 0, 0));
        add(0, 1, 8'h22, mo(1, 0, 4, 32'h2002_0000, 1, 0, 0, 0));
        add(0, 1, 8'h33, mo(1, 0, 4, 32'h2002_0000, 1, 0, 0, 0));
        add(0, 1, 8'h44, mo(0, 1, 0, 32'h4433_2211, 1, 0, 0, 0));
        add(0, 0, 8'h00, mo(0, 0, 0, 32'h4433_2211, 0, 1, 0, 1));
        // Capacity boundary: N=1024 is legal and enters DATA.
        add(1, 0, 8'h00, mo(1, 0, 0, 32'h4433_2211, 1, 0, 0, 0));
        add(0, 1, 8'h00, mo(1, 0, 0, 32'h4433_2211, 1, 0, 0, 0));
        add(0, 1, 8'h04, mo(1, 0, 0, 32'h4433_2211, 1, 0, 0, 0));

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].s; in_valid = tbl[i].v; in_data = tbl[i].d;
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), tbl[i].exp);
        end
        start = 1'b0; in_valid = 1'b0;
        chk("tbl_write_count", wa.size(), 3);

        // Test 4: test-1 stream with random gaps; valid held high through WRITE.
        do_reset();
        wa.delete(); wd.delete();
        pulse_start();
        begin
            logic [7:0] s4 [10];
            s4 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h20, 8'h00, 8'h00, 8'h02, 8'h20};
            for (int i = 0; i < 10; i++)
                send(s4[i], (i == 6) ? 0 : int'($urandom_range(0, 3)));
        end
        wait_done("gap_done");
        chk("gap_wcount", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("gap_a0", wa[0], 32'h0);
            chk("gap_d0", wd[0], 32'h2001_0000);
            chk("gap_a1", wa[1], 32'h4);
            chk("gap_d1", wd[1], 32'h2002_0000);
        end
        chk("gap_wl", {16'd0, words_loaded}, 2);
        chk("gap_hold", {31'd0, cpu_hold}, 0);

        // Test 5: reset after two data bytes of word 1, then a fresh load.
        wa.delete(); wd.delete();
        pulse_start();
        send(8'h01, 0); send(8'h00, 0); send(8'hAA, 0); send(8'hBB, 0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1 chk_out("async_reset", mo(0, 0, 0, 0, 1, 0, 0, 0));
        @(negedge clk); rst = 1'b1; @(negedge clk);
        pulse_start();
        send(8'h01, 0); send(8'h00, 1);
        send(8'h78, 0); send(8'h56, 2); send(8'h34, 0); send(8'h12, 1);
        wait_done("rst_reload_done");
        chk("rst_wcount", wa.size(), 1);
        if (wa.size() == 1) begin
            chk("rst_a0", wa[0], 32'h0);
            chk("rst_d0", wd[0], 32'h1234_5678);
        end

        // Test 6: start mid-DATA ignored; start in DONE reloads from 0.
        wa.delete(); wd.delete();
        pulse_start();
        send(8'h02, 0); send(8'h00, 0); send(8'h01, 0); send(8'h02, 0);
        in_valid = 1'b0;
        pulse_start();
        chk("mid_start_rdy", {31'd0, in_ready}, 1);
        send(8'h03, 0); send(8'h04, 0);
        send(8'h05, 0); send(8'h06, 0); send(8'h07, 0); send(8'h08, 0);
        wait_done("mid_done");
        chk("mid_wcount", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("mid_d0", wd[0], 32'h0403_0201);
            chk("mid_a1", wa[1], 32'h4);
            chk("mid_d1", wd[1], 32'h0807_0605);
        end
        chk("mid_wl", {16'd0, words_loaded}, 2);
        pulse_start();
        chk_out("reload_start", mo(1, 0, 4, 32'h0807_0605, 1, 0, 0, 0));
        wa.delete(); wd.delete();
        send(8'h01, 0); send(8'h00, 0);
        send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0);
        wait_done("reload_done");
        chk("reload_wl", {16'd0, words_loaded}, 1);
        chk("reload_wcount", wa.size(), 1);
        if (wa.size() == 1) begin
            chk("reload_a0", wa[0], 32'h0);
            chk("reload_d0", wd[0], 32'hDEAD_BEEF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
